// File: rtl/test_run_ctrl_if.sv
// Handshake bundle between the run sequencer and the generator / checker /
// scoreboard chain. The sequencer is the master; the chain is the slave.
interface test_run_ctrl_if;
    logic gen_valid;
    logic gen_ready;
    logic chk_valid;
    logic chk_mismatch;
    logic sb_reset_n;
    logic sb_event;

    modport master (
        output gen_valid,
        output sb_reset_n,
        output sb_event,
        input  gen_ready,
        input  chk_valid,
        input  chk_mismatch
    );

    modport slave (
        input  gen_valid,
        input  sb_reset_n,
        input  sb_event,
        output gen_ready,
        output chk_valid,
        output chk_mismatch
    );
endinterface

// File: rtl/test_run_ctrl.sv
// Run sequencer for the arithmetic testbench: clears the scoreboard, issues
// N stimulus requests, collects checker results, waits for the DUT pipeline
// to drain (with timeout) and reports done / pass / timeout / abort.
//
// state | meaning
// IDLE  | waiting for start; counters and flags hold the last run's values
// CLEAR | one cycle with the scoreboard clear asserted
// ISSUE | requesting stimulus until N transfers have been accepted
// DRAIN | waiting for the remaining results, drain timer running
// DONE  | one-cycle completion pulse, then back to IDLE
module test_run_ctrl #(
    parameter int CNT_W  = 24,
    parameter int LAT_W  = 8,
    parameter int MARGIN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_vectors,
    input  logic [LAT_W-1:0] i_latency,
    test_run_ctrl_if.master  bus,
    output logic [2:0]       o_state,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic             o_aborted,
    output logic [CNT_W-1:0] o_issued_ctr,
    output logic [CNT_W-1:0] o_checked_ctr,
    output logic [7:0]       o_err_ctr
);
    // Two spare bits so latency + MARGIN never wraps.
    localparam int TMR_W = LAT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_gen_valid;
    logic               r_sb_reset_n;
    logic               r_sb_event;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic               r_aborted;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_checked;
    logic [7:0]         r_err;
    logic [CNT_W-1:0]   r_num;
    logic [LAT_W-1:0]   r_lat;
    logic [TMR_W-1:0]   r_tmr;

    state_t             w_state_nxt;
    logic               w_active;
    logic               w_abort;
    logic               w_xfer;
    logic               w_last_xfer;
    logic               w_chk;
    logic               w_overrun;
    logic               w_err_inc;
    logic [CNT_W-1:0]   w_checked_nxt;
    logic [7:0]         w_err_nxt;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic               w_drain_ok;
    logic               w_drain_to;

    // Event decode and next-state selection; abort overrides every transition.
    always_comb begin
        w_active      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        w_abort       = i_abort && (r_state != S_IDLE);
        w_xfer        = r_gen_valid && bus.gen_ready && !w_abort;
        w_last_xfer   = w_xfer && ((r_issued + CNT_W'(1)) == r_num);
        w_chk         = bus.chk_valid && w_active && !w_abort;
        // A result with nothing outstanding is an overrun: an error, not a check.
        w_overrun     = w_chk && (r_checked == r_issued);
        w_checked_nxt = (w_chk && !w_overrun) ? r_checked + CNT_W'(1) : r_checked;
        w_err_inc     = w_chk && (w_overrun || bus.chk_mismatch);
        w_err_nxt     = (w_err_inc && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
        w_tmr_nxt     = (r_tmr != '0) ? r_tmr - TMR_W'(1) : '0;
        // The final result wins over the timer reaching zero on the same cycle.
        w_drain_ok    = (r_state == S_DRAIN) && (w_checked_nxt == r_num);
        w_drain_to    = (r_state == S_DRAIN) && !w_drain_ok && (w_tmr_nxt == '0);

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (i_num_vectors == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_last_xfer) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_ok || w_drain_to) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // State register, Moore outputs decoded from the next state, counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_gen_valid  <= 1'b0;
            r_sb_reset_n <= 1'b0;
            r_sb_event   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_aborted    <= 1'b0;
            r_issued     <= '0;
            r_checked    <= '0;
            r_err        <= '0;
            r_num        <= '0;
            r_lat        <= '0;
            r_tmr        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gen_valid  <= (w_state_nxt == S_ISSUE);
            r_sb_reset_n <= (w_state_nxt != S_CLEAR);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_sb_event   <= bus.chk_valid && bus.chk_mismatch && w_active;

            if (w_xfer) r_issued <= r_issued + CNT_W'(1);
            r_checked <= w_checked_nxt;
            r_err     <= w_err_nxt;

            if (w_last_xfer)
                r_tmr <= TMR_W'(r_lat) + TMR_W'(MARGIN);
            else if (r_state == S_DRAIN)
                r_tmr <= w_tmr_nxt;

            if (!w_abort && w_drain_to) r_timeout <= 1'b1;
            if (!w_abort && (w_drain_ok || w_drain_to))
                r_pass <= (w_err_nxt == 8'd0) && !w_drain_to && (w_checked_nxt == r_num);

            if (w_abort) begin
                r_aborted <= 1'b1;
                r_pass    <= 1'b0;
            end

            // Accepted start: latch the run parameters and wipe the last run's results.
            if ((r_state == S_IDLE) && i_start) begin
                r_num     <= i_num_vectors;
                r_lat     <= i_latency;
                r_issued  <= '0;
                r_checked <= '0;
                r_err     <= '0;
                r_tmr     <= '0;
                r_timeout <= 1'b0;
                r_aborted <= 1'b0;
                r_pass    <= (i_num_vectors == '0);
            end
        end
    end

    assign bus.gen_valid  = r_gen_valid;
    assign bus.sb_reset_n = r_sb_reset_n;
    assign bus.sb_event   = r_sb_event;
    assign o_state        = r_state;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_pass         = r_pass;
    assign o_timeout      = r_timeout;
    assign o_aborted      = r_aborted;
    assign o_issued_ctr   = r_issued;
    assign o_checked_ctr  = r_checked;
    assign o_err_ctr      = r_err;
endmodule

// File: tb/tb_test_run_ctrl.sv
// Bench for test_run_ctrl: a table of whole-run vectors driven through a
// small generator/checker model, plus hand sequences for overrun, abort in
// IDLE and reset in the middle of a run.
module tb_test_run_ctrl;
    localparam int CNT_W  = 24;
    localparam int LAT_W  = 8;
    localparam int BUDGET = 1000;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_num_vectors;
    logic [LAT_W-1:0] i_latency;
    logic             tb_gen_ready;
    logic             tb_chk_valid;
    logic             tb_chk_mismatch;
    logic [2:0]       o_state;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic             o_timeout;
    logic             o_aborted;
    logic [CNT_W-1:0] o_issued_ctr;
    logic [CNT_W-1:0] o_checked_ctr;
    logic [7:0]       o_err_ctr;

    always #5 clk = ~clk;

    test_run_ctrl_if bus ();
    assign bus.gen_ready    = tb_gen_ready;
    assign bus.chk_valid    = tb_chk_valid;
    assign bus.chk_mismatch = tb_chk_mismatch;

    test_run_ctrl #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MARGIN(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_num_vectors (i_num_vectors),
        .i_latency     (i_latency),
        .bus           (bus),
        .o_state       (o_state),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_pass        (o_pass),
        .o_timeout     (o_timeout),
        .o_aborted     (o_aborted),
        .o_issued_ctr  (o_issued_ctr),
        .o_checked_ctr (o_checked_ctr),
        .o_err_ctr     (o_err_ctr)
    );

    // n: run length, lat: i_latency, rd: result delay after transfer,
    // rdy: 0 ready tied high / 1 ready toggling, lim: results returned,
    // mm: 0 none / 1 all / 2 every other result mismatches,
    // ab: abort after this many transfers (0 none), bs: start pulse while busy.
    typedef struct {
        int n, lat, rd, rdy, lim, mm, ab, bs;
        int e_iss, e_chk, e_err, e_pass, e_to, e_abt, e_done;
        int e_gv, e_issue, e_drain, e_ev, e_st0;
    } vec_t;

    vec_t vt[9];

    int checks = 0;
    int errors = 0;

    int ob_gv, ob_done, ob_ev, ob_issue, ob_drain, ob_st0, ob_sbr0, ob_evmis, ob_tout;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete run and records what the DUT did cycle by cycle.
    task automatic run_vec(input vec_t v);
        int  cyc;
        int  xfers;
        int  nres;
        int  due[$];
        bit  prev_ev;
        bit  xfer_now;
        ob_gv = 0; ob_done = 0; ob_ev = 0; ob_issue = 0; ob_drain = 0;
        ob_evmis = 0; ob_tout = 0;
        i_num_vectors   = CNT_W'(v.n);
        i_latency       = LAT_W'(v.lat);
        i_abort         = 1'b0;
        tb_gen_ready    = 1'b0;
        tb_chk_valid    = 1'b0;
        tb_chk_mismatch = 1'b0;
        i_start         = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0; xfers = 0; nres = 0; prev_ev = 1'b0;
        ob_st0  = int'(o_state);
        ob_sbr0 = int'(bus.sb_reset_n);
        forever begin
            if (bus.sb_event !== prev_ev) ob_evmis++;
            if (bus.gen_valid) ob_gv++;
            if (o_done) ob_done++;
            if (bus.sb_event) ob_ev++;
            if (o_state == 3'd2) ob_issue++;
            if (o_state == 3'd3) ob_drain++;
            if (o_state == 3'd0) break;
            if (cyc >= BUDGET) begin
                ob_tout = 1;
                break;
            end
            i_start       = 1'b0;
            i_num_vectors = CNT_W'(v.n);
            if (v.bs != 0 && cyc == 3) begin
                i_start       = 1'b1;
                i_num_vectors = CNT_W'(99);
            end
            i_abort      = (v.ab != 0) && (xfers == v.ab);
            tb_gen_ready = i_abort ? 1'b0 : ((v.rdy != 0) ? (cyc % 2 == 1) : 1'b1);
            tb_chk_valid    = 1'b0;
            tb_chk_mismatch = 1'b0;
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                if (nres < v.lim && !i_abort) begin
                    tb_chk_valid    = 1'b1;
                    tb_chk_mismatch = (v.mm == 1) || (v.mm == 2 && nres % 2 == 1);
                end
                nres++;
            end
            prev_ev  = tb_chk_valid & tb_chk_mismatch;
            xfer_now = bus.gen_valid & tb_gen_ready;
            tick();
            cyc++;
            if (xfer_now) begin
                xfers++;
                due.push_back(cyc + v.rd);
            end
        end
        i_start         = 1'b0;
        i_abort         = 1'b0;
        tb_gen_ready    = 1'b0;
        tb_chk_valid    = 1'b0;
        tb_chk_mismatch = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_num_vectors = '0; i_latency = '0;
        tb_gen_ready = 1'b0; tb_chk_valid = 1'b0; tb_chk_mismatch = 1'b0;

        //          n   lat rd rdy lim mm ab  bs   iss chk err pass to abt done gv  issue drain ev st0
        vt[0] = '{  4,  3,  3, 0,  4,  0, 0,  0,   4,  4,  0,  1,   0, 0,  1,   4,  4,    4,   0,  1};
        vt[1] = '{  5,  3,  3, 1,  5,  0, 0,  1,   5,  5,  0,  1,   0, 0,  1,   9,  9,    4,   0,  1};
        vt[2] = '{300,  3,  3, 0, 300, 1, 0,  0, 300, 300,255, 0,   0, 0,  1, 300, 300,   4, 300,  1};
        vt[3] = '{  3,  2,  2, 0,  2,  0, 0,  0,   3,  2,  0,  0,   1, 0,  1,   3,  3,   18,   0,  1};
        vt[4] = '{100,  3,  3, 0, 100, 0, 10, 0,  10,  6,  0,  0,   0, 1,  0,  11, 11,    0,   0,  1};
        vt[5] = '{  0,  3,  3, 0,  0,  0, 0,  0,   0,  0,  0,  1,   0, 0,  1,   0,  0,    0,   0,  4};
        vt[6] = '{  1,  0, 15, 0,  1,  0, 0,  0,   1,  1,  0,  1,   0, 0,  1,   1,  1,   16,   0,  1};
        vt[7] = '{  1,  0, 16, 0,  1,  0, 0,  0,   1,  0,  0,  0,   1, 0,  1,   1,  1,   16,   0,  1};
        vt[8] = '{  6,  1,  1, 0,  6,  2, 0,  0,   6,  6,  3,  0,   0, 0,  1,   6,  6,    2,   3,  1};

        tick();
        tick();
        chk("rst.state",      o_state, 0);
        chk("rst.gen_valid",  bus.gen_valid, 0);
        chk("rst.sb_reset_n", bus.sb_reset_n, 0);
        chk("rst.sb_event",   bus.sb_event, 0);
        chk("rst.busy",       o_busy, 0);
        chk("rst.done",       o_done, 0);
        chk("rst.pass",       o_pass, 0);
        chk("rst.timeout",    o_timeout, 0);
        chk("rst.aborted",    o_aborted, 0);
        chk("rst.issued",     o_issued_ctr, 0);
        chk("rst.checked",    o_checked_ctr, 0);
        chk("rst.err",        o_err_ctr, 0);
        reset = 1'b0;
        tick();
        chk("idle.sb_reset_n", bus.sb_reset_n, 1);
        chk("idle.state",      o_state, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vt[i]);
            chk($sformatf("v%0d.cycle_budget", i), ob_tout, 0);
            chk($sformatf("v%0d.first_state", i), ob_st0, vt[i].e_st0);
            chk($sformatf("v%0d.first_sb_reset_n", i), ob_sbr0, (vt[i].n == 0) ? 1 : 0);
            chk($sformatf("v%0d.issued", i), o_issued_ctr, vt[i].e_iss);
            chk($sformatf("v%0d.checked", i), o_checked_ctr, vt[i].e_chk);
            chk($sformatf("v%0d.err", i), o_err_ctr, vt[i].e_err);
            chk($sformatf("v%0d.pass", i), o_pass, vt[i].e_pass);
            chk($sformatf("v%0d.timeout", i), o_timeout, vt[i].e_to);
            chk($sformatf("v%0d.aborted", i), o_aborted, vt[i].e_abt);
            chk($sformatf("v%0d.done_pulses", i), ob_done, vt[i].e_done);
            chk($sformatf("v%0d.gen_valid_cycles", i), ob_gv, vt[i].e_gv);
            chk($sformatf("v%0d.issue_cycles", i), ob_issue, vt[i].e_issue);
            chk($sformatf("v%0d.drain_cycles", i), ob_drain, vt[i].e_drain);
            chk($sformatf("v%0d.sb_event_pulses", i), ob_ev, vt[i].e_ev);
            chk($sformatf("v%0d.sb_event_alignment", i), ob_evmis, 0);
            chk($sformatf("v%0d.busy_after", i), o_busy, 0);
            if (ob_tout != 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                tick();
            end
        end

        // Results with nothing outstanding are overruns; then abort, then abort in IDLE.
        i_num_vectors = CNT_W'(2); i_latency = LAT_W'(0); tb_gen_ready = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tb_chk_valid = 1'b1; tb_chk_mismatch = 1'b0;
        tick();
        tb_chk_valid = 1'b0;
        chk("ovr.err",       o_err_ctr, 1);
        chk("ovr.checked",   o_checked_ctr, 0);
        chk("ovr.issued",    o_issued_ctr, 0);
        chk("ovr.gen_valid", bus.gen_valid, 1);
        chk("ovr.sb_event",  bus.sb_event, 0);
        tb_chk_valid = 1'b1; tb_chk_mismatch = 1'b1;
        tick();
        tb_chk_valid = 1'b0; tb_chk_mismatch = 1'b0;
        chk("ovr2.err",      o_err_ctr, 2);
        chk("ovr2.sb_event", bus.sb_event, 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abt.state",     o_state, 0);
        chk("abt.gen_valid", bus.gen_valid, 0);
        chk("abt.aborted",   o_aborted, 1);
        chk("abt.done",      o_done, 0);
        chk("abt.err_hold",  o_err_ctr, 2);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        chk("idle_abt.state",   o_state, 0);
        chk("idle_abt.aborted", o_aborted, 1);
        chk("idle_abt.done",    o_done, 0);

        // Reset in the middle of ISSUE.
        i_num_vectors = CNT_W'(10); i_latency = LAT_W'(3); tb_gen_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid.state",     o_state, 2);
        chk("mid.busy",      o_busy, 1);
        chk("mid.gen_valid", bus.gen_valid, 1);
        chk("mid.issued",    o_issued_ctr, 2);
        reset = 1'b1;
        tick();
        chk("midrst.state",      o_state, 0);
        chk("midrst.gen_valid",  bus.gen_valid, 0);
        chk("midrst.sb_reset_n", bus.sb_reset_n, 0);
        chk("midrst.busy",       o_busy, 0);
        chk("midrst.done",       o_done, 0);
        chk("midrst.issued",     o_issued_ctr, 0);
        chk("midrst.checked",    o_checked_ctr, 0);
        chk("midrst.err",        o_err_ctr, 0);
        chk("midrst.aborted",    o_aborted, 0);
        reset = 1'b0; tb_gen_ready = 1'b0;
        tick();
        chk("postrst.sb_reset_n", bus.sb_reset_n, 1);
        chk("postrst.state",      o_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
